// File: rtl/lane_hit_judge_if.sv
// Lane block-position / judgement bundle between a lane's block
// generator, the player key, and the hit judge.
// master: the side that drives block_h/key and consumes results.
// slave : the hit judge.
interface lane_hit_judge_if;
  logic [9:0]  block_h;
  logic        key;
  logic        hit_perfect;
  logic        hit_good;
  logic        miss;
  logic [13:0] score;
  logic [6:0]  combo;
  logic        block_visible;

  modport master (
    output block_h, key,
    input  hit_perfect, hit_good, miss, score, combo, block_visible
  );

  modport slave (
    input  block_h, key,
    output hit_perfect, hit_good, miss, score, combo, block_visible
  );
endinterface

// File: rtl/lane_hit_judge.sv
// Per-lane hit judge: watches the falling block position and the lane key,
// judges each block once (perfect / good / miss), and keeps score and combo.
// Optional macro GHOST_PENALTY_EN: a key press with no live block counts
// as a miss (combo cleared, score unchanged).
module lane_hit_judge #(
  parameter int HIT_LO      = 600,
  parameter int HIT_HI      = 690,
  parameter int PERF_LO     = 630,
  parameter int PERF_HI     = 660,
  parameter int PERFECT_PTS = 3,
  parameter int GOOD_PTS    = 1,
  parameter int SCORE_MAX   = 9999,
  parameter int COMBO_MAX   = 99
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic stop_or_endgame,
  lane_hit_judge_if.slave lane
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [9:0]  PARK_H      = 10'd720;
  localparam logic [9:0]  HIT_LO_H    = 10'(HIT_LO);
  localparam logic [9:0]  HIT_HI_H    = 10'(HIT_HI);
  localparam logic [9:0]  PERF_LO_H   = 10'(PERF_LO);
  localparam logic [9:0]  PERF_HI_H   = 10'(PERF_HI);
  localparam logic [14:0] PERF_PTS_W  = 15'(PERFECT_PTS);
  localparam logic [14:0] GOOD_PTS_W  = 15'(GOOD_PTS);
  localparam logic [14:0] SCORE_MAX_W = 15'(SCORE_MAX);
  localparam logic [7:0]  COMBO_MAX_W = 8'(COMBO_MAX);

  state_e      state_q, state_d;
  logic [9:0]  prev_h_q, prev_h_d;
  logic        key_d_q, key_d_d;
  logic [13:0] score_q, score_d;
  logic [6:0]  combo_q, combo_d;
  logic        hit_perfect_q, hit_perfect_d;
  logic        hit_good_q, hit_good_d;
  logic        miss_q, miss_d;
  logic        block_visible_q, block_visible_d;

  logic        key_edge;
  logic        spawn;
  logic        h_early;
  logic        h_in_hit;
  logic        h_in_perf;
  logic        h_late;
  logic [14:0] score_sum;
  logic [7:0]  combo_sum;

  // Decode key edge, spawn and position windows from the current sample.
  always_comb begin
    key_edge  = lane.key & ~key_d_q;
    spawn     = (lane.block_h < prev_h_q);
    h_early   = (lane.block_h < HIT_LO_H);
    h_in_hit  = (lane.block_h >= HIT_LO_H) && (lane.block_h <= HIT_HI_H);
    h_in_perf = (lane.block_h >= PERF_LO_H) && (lane.block_h <= PERF_HI_H);
    h_late    = (lane.block_h > HIT_HI_H);
  end

  // Judgement FSM plus saturating score/combo update.
  always_comb begin
    state_d       = state_q;
    prev_h_d      = prev_h_q;
    key_d_d       = lane.key;
    score_d       = score_q;
    combo_d       = combo_q;
    hit_perfect_d = 1'b0;
    hit_good_d    = 1'b0;
    miss_d        = 1'b0;
    score_sum     = '0;
    combo_sum     = '0;

    if (restart) begin
      state_d  = IDLE;
      prev_h_d = PARK_H;
      key_d_d  = 1'b0;
      score_d  = '0;
      combo_d  = '0;
    end else if (!stop_or_endgame) begin
      prev_h_d = lane.block_h;
      case (state_q)
        ARMED: begin
          // A respawn while armed means the old block went unjudged; the
          // new block keeps the FSM armed and any same-cycle press is dropped.
          if (spawn) begin
            miss_d = 1'b1;
          end else if (key_edge && h_early) begin
            miss_d  = 1'b1;
            state_d = DONE;
          end else if (key_edge && h_in_hit) begin
            hit_perfect_d = h_in_perf;
            hit_good_d    = ~h_in_perf;
            state_d       = DONE;
          end else if (h_late) begin
            miss_d  = 1'b1;
            state_d = DONE;
          end
        end
        default: begin
          if (spawn) begin
            state_d = ARMED;
          end
`ifdef GHOST_PENALTY_EN
          else if (key_edge) begin
            miss_d = 1'b1;
          end
`endif
        end
      endcase

      score_sum = {1'b0, score_q} + (hit_perfect_d ? PERF_PTS_W : GOOD_PTS_W);
      combo_sum = {1'b0, combo_q} + 8'd1;
      if (hit_perfect_d || hit_good_d) begin
        score_d = (score_sum > SCORE_MAX_W) ? SCORE_MAX_W[13:0] : score_sum[13:0];
        combo_d = (combo_sum > COMBO_MAX_W) ? COMBO_MAX_W[6:0] : combo_sum[6:0];
      end else if (miss_d) begin
        combo_d = '0;
      end
    end

    block_visible_d = (state_d == ARMED);
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      prev_h_q        <= PARK_H;
      key_d_q         <= 1'b0;
      score_q         <= '0;
      combo_q         <= '0;
      hit_perfect_q   <= 1'b0;
      hit_good_q      <= 1'b0;
      miss_q          <= 1'b0;
      block_visible_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      prev_h_q        <= prev_h_d;
      key_d_q         <= key_d_d;
      score_q         <= score_d;
      combo_q         <= combo_d;
      hit_perfect_q   <= hit_perfect_d;
      hit_good_q      <= hit_good_d;
      miss_q          <= miss_d;
      block_visible_q <= block_visible_d;
    end
  end

  assign lane.hit_perfect   = hit_perfect_q;
  assign lane.hit_good      = hit_good_q;
  assign lane.miss          = miss_q;
  assign lane.score         = score_q;
  assign lane.combo         = combo_q;
  assign lane.block_visible = block_visible_q;

endmodule

// File: tb/tb_lane_hit_judge.sv
// Scoreboard bench for lane_hit_judge: a behavioural lane model predicts
// each cycle's outputs when inputs are driven; results are popped and
// compared one cycle later.
module tb_lane_hit_judge;

  logic clk;
  logic rst_n;
  logic restart;
  logic stop_or_endgame;

  lane_hit_judge_if lane_bus ();

  lane_hit_judge dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .restart         (restart),
    .stop_or_endgame (stop_or_endgame),
    .lane            (lane_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned perf;
    int unsigned good;
    int unsigned miss;
    int unsigned score;
    int unsigned combo;
    int unsigned vis;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Lane model state (0 idle, 1 armed, 2 done).
  int m_state;
  int m_prev;
  int m_keyd;
  int m_score;
  int m_combo;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_prev  = 720;
    m_keyd  = 0;
    m_score = 0;
    m_combo = 0;
  endtask

  function automatic int add_sat(input int v, input int inc, input int lim);
    return (v + inc > lim) ? lim : v + inc;
  endfunction

  // Predict outputs for the coming edge, push them, clock, then compare.
  task automatic step();
    exp_t e;
    int h, k, kedge, sp;
    exp_t got;
    h = int'(lane_bus.block_h);
    k = int'(lane_bus.key);
    e.perf = 0; e.good = 0; e.miss = 0;
    if (restart) begin
      model_reset();
    end else if (!stop_or_endgame) begin
      kedge = (k == 1 && m_keyd == 0) ? 1 : 0;
      sp    = (h < m_prev) ? 1 : 0;
      if (m_state == 1) begin
        if (sp == 1) begin
          e.miss = 1;
        end else if (kedge == 1 && h < 600) begin
          e.miss = 1; m_state = 2;
        end else if (kedge == 1 && h <= 690) begin
          if (h >= 630 && h <= 660) begin
            e.perf = 1; m_score = add_sat(m_score, 3, 9999);
          end else begin
            e.good = 1; m_score = add_sat(m_score, 1, 9999);
          end
          m_combo = add_sat(m_combo, 1, 99);
          m_state = 2;
        end else if (h > 690) begin
          e.miss = 1; m_state = 2;
        end
      end else if (sp == 1) begin
        m_state = 1;
      end else if (kedge == 1) begin
`ifdef GHOST_PENALTY_EN
        e.miss = 1;
`endif
      end
      if (e.miss == 1) m_combo = 0;
      m_prev = h;
    end
    if (!restart) m_keyd = k;
    e.score = m_score;
    e.combo = m_combo;
    e.vis   = (m_state == 1) ? 1 : 0;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_eq("hit_perfect",   lane_bus.hit_perfect,   got.perf);
    check_eq("hit_good",      lane_bus.hit_good,      got.good);
    check_eq("miss",          lane_bus.miss,          got.miss);
    check_eq("score",         lane_bus.score,         got.score);
    check_eq("combo",         lane_bus.combo,         got.combo);
    check_eq("block_visible", lane_bus.block_visible, got.vis);
  endtask

  task automatic drive(input int h, input int k);
    lane_bus.block_h = 10'(h);
    lane_bus.key     = k[0];
    step();
  endtask

  // Spawn a block, press at position h, release.
  task automatic press_block(input int h);
    drive(120, 0);
    drive(h, 1);
    drive(h + 1, 0);
  endtask

  task automatic walk(input int lo, input int hi, input int k);
    for (int h = lo; h <= hi; h++) drive(h, k);
  endtask

  initial begin
    rst_n           = 1'b0;
    restart         = 1'b0;
    stop_or_endgame = 1'b0;
    lane_bus.block_h = 10'd720;
    lane_bus.key     = 1'b0;
    model_reset();

    // Reset values held while rst_n is low.
    #12;
    check_eq("rst_perfect", lane_bus.hit_perfect,   0);
    check_eq("rst_good",    lane_bus.hit_good,      0);
    check_eq("rst_miss",    lane_bus.miss,          0);
    check_eq("rst_score",   lane_bus.score,         0);
    check_eq("rst_combo",   lane_bus.combo,         0);
    check_eq("rst_visible", lane_bus.block_visible, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Parked idle, then perfect hit and trailing cycles with no pulse.
    drive(720, 0);
    drive(720, 0);
    drive(120, 0);
    drive(121, 0);
    drive(645, 1);
    walk(646, 650, 0);
    walk(688, 693, 0);

    // Restart, then good hits at both window edges and an early miss.
    restart = 1'b1;
    drive(693, 0);
    restart = 1'b0;
    press_block(600);
    press_block(690);
    press_block(599);

    // Late miss (only at 691), then a key press with no live block.
    drive(120, 0);
    walk(684, 695, 0);
    drive(700, 1);
    drive(701, 0);

    // Respawn while armed with a simultaneous press, then a perfect hit.
    drive(120, 0);
    drive(300, 0);
    drive(120, 1);
    drive(200, 0);
    drive(640, 1);
    drive(641, 0);

    // Freeze with a press at 640, release with key held, then a fresh press.
    drive(120, 0);
    drive(630, 0);
    stop_or_endgame = 1'b1;
    drive(640, 1);
    drive(640, 1);
    stop_or_endgame = 1'b0;
    drive(640, 1);
    drive(641, 0);
    drive(642, 1);
    drive(643, 0);

    // Saturation of score and combo.
    restart = 1'b1;
    drive(720, 0);
    restart = 1'b0;
    for (int i = 0; i < 3333; i++) press_block(645);
    press_block(610);
    press_block(645);

    // Asynchronous reset while a block is armed.
    drive(120, 0);
    drive(300, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("areset_score",   lane_bus.score,         0);
    check_eq("areset_combo",   lane_bus.combo,         0);
    check_eq("areset_visible", lane_bus.block_visible, 0);
    check_eq("areset_miss",    lane_bus.miss,          0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(300, 0);
    drive(301, 0);
    press_block(650);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
